tlut_mvm_engine: RTL and testbench
==================================

Name: tlut_mvm_engine

Overview:
Parametrised temporal-LUT matrix-vector multiply engine and successor to the fixed-size TLUT SIMD cell. It computes result[c] = sum over a of in[a]*w[c][a] for DIM_C output channels. Each input is encoded as a unary/temporal pulse train against a rollover counter, and per-lane weight accumulation stands in for the multiplier. A pipelined adder tree reduces the DIM_A lanes per channel. Compared with the previous cell, it adds a valid/ready operand and result handshake, runtime input precision, optional signed weights and stall support.

Parameters:
DIM_A, 4, number of input lanes (reduction length), >=1
DIM_C, 2, number of output channels, >=1
INPUT_WIDTH, 4, max input bits (unsigned)
WEIGHT_WIDTH, 4, weight bits
SIGNED_W, 0, 1 = weights are two's complement and sign-extended; 0 = unsigned
ACC_WIDTH, WEIGHT_WIDTH+INPUT_WIDTH+$clog2(DIM_A), width of lane accumulators, tree nodes and results
TREE_STAGES, derived = $clog2(DIM_A), registered adder-tree levels (0 when DIM_A=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  run gate; low freezes RUN/DRAIN progress
in_valid  in  1  operand bundle valid
in_ready  out  1  engine can accept operands
in_vec  in  DIM_A*INPUT_WIDTH  unsigned inputs, lane a at bits [a*IW +: IW]
w_mat  in  DIM_C*DIM_A*WEIGHT_WIDTH  weights, w[c][a] at index c*DIM_A+a
prec  in  $clog2(INPUT_WIDTH+1)  effective input bits p; 0 or >INPUT_WIDTH means INPUT_WIDTH
out_valid  out  1  results valid
out_ready  in  1  consumer accepts results
result  out  DIM_C*ACC_WIDTH  dot products, channel c at [c*ACC_WIDTH +: ACC_WIDTH]
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter, lane accumulators, tree registers and captured operands all 0.
- FSM states and transitions:
  - IDLE -> RUN on in_valid&&in_ready. At that edge: capture in_vec, w_mat and resolved p; mask input bits >= p to 0; clear accumulators; cnt=0.
  - RUN: each enabled cycle, acc[c][a] += ext(w[c][a]) when cnt < in[a], then cnt++. Leave RUN after the enabled cycle with cnt = 2^p-2, i.e. after 2^p-1 enabled cycles.
  - DRAIN: the tree advances one level per enabled cycle. After TREE_STAGES enabled cycles, load result and move to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready, go to IDLE; in_ready is high the next cycle.
- Latency: with enable held high, out_valid rises exactly 2^p + TREE_STAGES cycles after the accept edge. Each enable-low cycle during RUN/DRAIN adds one cycle.
- in_ready=1 only in IDLE. in_valid outside IDLE is ignored; no operand is queued.
- enable low: cnt, accumulators, tree registers and state hold. enable does not affect IDLE accept or the DONE handshake.
- Arithmetic: ext() zero-extends (SIGNED_W=0) or sign-extends (SIGNED_W=1) to ACC_WIDTH. Sums wrap modulo 2^ACC_WIDTH; there is no saturation. The default ACC_WIDTH cannot overflow.
- Boundaries:
  - in[a]=0 contributes 0.
  - in[a]=2^p-1 contributes (2^p-1)*w.
  - p=1 gives a RUN of 1 cycle.
  - DIM_A=1 gives no tree registers; result = acc.
- result is stable while out_valid=1 and out_ready=0. It retains its last value after the handshake until the next load.

Test Plan:
1. DIM_A=4, DIM_C=2, IW=WW=4, p=4; in=[1,2,3,4], w[0]=[1,1,1,1], w[1]=[2,0,3,1] -> result[0]=10, result[1]=15; out_valid exactly 18 cycles after accept; busy high throughout.
2. p=2, in=[7,3,1,0] (masked to [3,3,1,0]), w[0]=[1,1,1,1], w[1]=[15,15,15,15] -> result=[7,105]; latency 6 cycles.
3. SIGNED_W=1, p=4, in all 15; w[0]=[4'hF,2,0,0], w[1]=[4'h8 x4] -> result[0]=15, result[1]=-480 (10-bit 0x220).
4. Case 1 with enable low for 5 cycles mid-RUN and 1 cycle in DRAIN -> same results; latency 24 cycles.
5. Case 1 with out_ready low for 10 cycles after out_valid, and in_valid pulsed meanwhile -> result held, in_ready=0, no new capture; after the handshake, in_ready=1 next cycle and a back-to-back op gives correct results.
6. Assert rst mid-RUN of case 1 -> all outputs 0 and in_ready=1 immediately; after release, case 2 operands give [7,105].

Source files
------------

// File: rtl/tlut_mvm_engine.sv
// Temporal-LUT matrix-vector multiply engine: unary-coded inputs gate per-lane weight
// accumulation, then a registered adder tree reduces the lanes of each output channel.
module tlut_mvm_engine #(
    parameter int unsigned DIM_A        = 4,
    parameter int unsigned DIM_C        = 2,
    parameter int unsigned INPUT_WIDTH  = 4,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter bit          SIGNED_W     = 1'b0,
    parameter int unsigned ACC_WIDTH    = WEIGHT_WIDTH + INPUT_WIDTH + $clog2(DIM_A),
    parameter int unsigned TREE_STAGES  = $clog2(DIM_A)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DIM_A*INPUT_WIDTH-1:0]          in_vec,
    input  logic [DIM_C*DIM_A*WEIGHT_WIDTH-1:0]   w_mat,
    input  logic [$clog2(INPUT_WIDTH+1)-1:0]      prec,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DIM_C*ACC_WIDTH-1:0]            result,
    output logic                                  busy
);

    localparam int unsigned IW   = INPUT_WIDTH;
    localparam int unsigned WW   = WEIGHT_WIDTH;
    localparam int unsigned AW   = ACC_WIDTH;
    localparam int unsigned PW   = $clog2(INPUT_WIDTH + 1);
    localparam int unsigned NPad = 1 << TREE_STAGES;
    localparam int unsigned DW   = $clog2(TREE_STAGES + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        in_q   [DIM_A];
    logic [WW-1:0]        w_q    [DIM_C][DIM_A];
    logic [AW-1:0]        acc_q  [DIM_C][DIM_A];
    logic [AW-1:0]        wext   [DIM_C][DIM_A];
    logic [AW-1:0]        root   [DIM_C];
    logic [PW-1:0]        p_q;
    logic [IW-1:0]        cnt_q;
    logic [DW-1:0]        dcnt_q;
    logic [DIM_C*AW-1:0]  result_q;

    logic [PW-1:0]        p_res;
    logic [IW-1:0]        in_mask;
    logic [IW-1:0]        cnt_last;
    logic                 accept, run_step, run_last, drain_step, drain_last;

    always_comb begin
        p_res = prec;
        if (prec == '0 || prec > PW'(IW)) begin
            p_res = PW'(IW);
        end
        for (int b = 0; b < int'(IW); b++) begin
            in_mask[b] = (b < int'(p_res));
        end
        // Final RUN cycle has cnt = 2^p - 2, so that counts 0..2^p-2 cover inputs up to 2^p-1.
        cnt_last = IW'((32'd1 << p_q) - 32'd2);
    end

    assign accept     = (state_q == StIdle) && in_valid;
    assign run_step   = (state_q == StRun) && enable;
    assign run_last   = run_step && (cnt_q == cnt_last);
    assign drain_step = (state_q == StDrain) && enable;
    assign drain_last = drain_step && (dcnt_q == DW'(TREE_STAGES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept)     state_d = StRun;
            StRun:   if (run_last)   state_d = StDrain;
            StDrain: if (drain_last) state_d = StDone;
            StDone:  if (out_ready)  state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q      <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            result_q <= '0;
            for (int a = 0; a < int'(DIM_A); a++) begin
                in_q[a] <= '0;
            end
            for (int c = 0; c < int'(DIM_C); c++) begin
                for (int a = 0; a < int'(DIM_A); a++) begin
                    w_q[c][a]   <= '0;
                    acc_q[c][a] <= '0;
                end
            end
        end else begin
            if (accept) begin
                p_q    <= p_res;
                cnt_q  <= '0;
                dcnt_q <= '0;
                for (int a = 0; a < int'(DIM_A); a++) begin
                    in_q[a] <= in_vec[a*IW +: IW] & in_mask;
                end
                for (int c = 0; c < int'(DIM_C); c++) begin
                    for (int a = 0; a < int'(DIM_A); a++) begin
                        w_q[c][a]   <= w_mat[(c*DIM_A+a)*WW +: WW];
                        acc_q[c][a] <= '0;
                    end
                end
            end
            if (run_step) begin
                cnt_q <= cnt_q + 1'b1;
                for (int c = 0; c < int'(DIM_C); c++) begin
                    for (int a = 0; a < int'(DIM_A); a++) begin
                        if (cnt_q < in_q[a]) begin
                            acc_q[c][a] <= acc_q[c][a] + wext[c][a];
                        end
                    end
                end
            end
            if (drain_step) begin
                dcnt_q <= dcnt_q + 1'b1;
            end
            if (drain_last) begin
                for (int c = 0; c < int'(DIM_C); c++) begin
                    result_q[c*AW +: AW] <= root[c];
                end
            end
        end
    end

    for (genvar c = 0; c < DIM_C; c++) begin : g_chan
        for (genvar a = 0; a < DIM_A; a++) begin : g_ext
            if (SIGNED_W) begin : g_sext
                assign wext[c][a] = AW'($signed(w_q[c][a]));
            end else begin : g_zext
                assign wext[c][a] = AW'(w_q[c][a]);
            end
        end

        // Leaves are padded to a power of two with zeros so the tree is a full heap.
        logic [AW-1:0] leaf [NPad];
        for (genvar j = 0; j < NPad; j++) begin : g_leaf
            if (j < DIM_A) begin : g_real
                assign leaf[j] = acc_q[c][j];
            end else begin : g_pad
                assign leaf[j] = '0;
            end
        end

        if (TREE_STAGES == 0) begin : g_notree
            assign root[c] = leaf[0];
        end else begin : g_tree
            // Heap numbering: node k sums children 2k and 2k+1; indices >= NPad are leaves.
            for (genvar k = 1; k < NPad; k++) begin : g_node
                logic [AW-1:0] lhs, rhs, sum_q;
                if (2 * k >= NPad) begin : g_kids_leaf
                    assign lhs = leaf[2*k-NPad];
                    assign rhs = leaf[2*k+1-NPad];
                end else begin : g_kids_node
                    assign lhs = g_node[2*k].sum_q;
                    assign rhs = g_node[2*k+1].sum_q;
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sum_q <= '0;
                    end else if (drain_step) begin
                        sum_q <= lhs + rhs;
                    end
                end
            end
            assign root[c] = g_node[1].sum_q;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign result    = result_q;

endmodule

// File: tb/tb_tlut_mvm_engine.sv
// Scoreboard bench for tlut_mvm_engine: an unsigned-weight and a signed-weight instance share
// stimulus; expected results and latencies come from a direct dot-product model.
module tb_tlut_mvm_engine;

    localparam int DA = 4;
    localparam int DC = 2;
    localparam int IW = 4;
    localparam int WW = 4;
    localparam int AW = 10;
    localparam int RW = DC * AW;

    logic              clk = 1'b0;
    logic              rst, enable, in_valid, in_valid_s, out_ready;
    logic [DA*IW-1:0]  in_vec;
    logic [DC*DA*WW-1:0] w_mat;
    logic [2:0]        prec;
    logic              in_ready_u, out_valid_u, busy_u;
    logic              in_ready_s, out_valid_s, busy_s;
    logic [RW-1:0]     result_u, result_s;

    bit                use_s;
    logic              in_valid_m, in_ready_m, out_valid_m, busy_m;
    logic [RW-1:0]     result_m;

    assign in_valid_m  = use_s ? in_valid_s  : in_valid;
    assign in_ready_m  = use_s ? in_ready_s  : in_ready_u;
    assign out_valid_m = use_s ? out_valid_s : out_valid_u;
    assign busy_m      = use_s ? busy_s      : busy_u;
    assign result_m    = use_s ? result_s    : result_u;

    typedef struct {
        logic [RW-1:0] res;
        int            lat;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   inflight = 0;
    bit   seen = 0;

    always #5 clk = ~clk;

    tlut_mvm_engine #(
        .DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .SIGNED_W(1'b0)
    ) dut_u (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_vec(in_vec), .w_mat(w_mat), .prec(prec), .out_valid(out_valid_u),
        .out_ready(out_ready), .result(result_u), .busy(busy_u)
    );

    tlut_mvm_engine #(
        .DIM_A(DA), .DIM_C(DC), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW), .SIGNED_W(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_vec(in_vec), .w_mat(w_mat), .prec(prec), .out_valid(out_valid_s),
        .out_ready(out_ready), .result(result_s), .busy(busy_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int peff(input int p);
        return (p == 0 || p > IW) ? IW : p;
    endfunction

    function automatic logic [RW-1:0] model(input logic [DA*IW-1:0] iv,
                                            input logic [DC*DA*WW-1:0] wm,
                                            input int p, input bit sgn);
        logic [RW-1:0] r;
        logic [WW-1:0] nib;
        int pe, x, wv, sum;
        pe = peff(p);
        r  = '0;
        for (int c = 0; c < DC; c++) begin
            sum = 0;
            for (int a = 0; a < DA; a++) begin
                x   = int'(iv[a*IW +: IW]) & ((1 << pe) - 1);
                nib = wm[(c*DA+a)*WW +: WW];
                wv  = int'(nib);
                if (sgn && nib[WW-1]) wv -= (1 << WW);
                sum += x * wv;
            end
            r[c*AW +: AW] = AW'(sum);
        end
        return r;
    endfunction

    // Called at #1 after a clock edge; returns #1 after the accept edge.
    task automatic issue(input logic [DA*IW-1:0] iv, input logic [DC*DA*WW-1:0] wm,
                         input int p, input bit push, input int extra_lat);
        int   k = 0;
        exp_t e;
        while (!in_ready_m && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check("accept_ready", in_ready_m, 1'b1);
        in_vec = iv;
        w_mat  = wm;
        prec   = 3'(p);
        if (use_s) in_valid_s = 1'b1;
        else       in_valid   = 1'b1;
        if (push) begin
            e.res = model(iv, wm, p, use_s);
            e.lat = (1 << peff(p)) + 2 + extra_lat;
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (q.size() != 0) begin
            check("timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            inflight = 0;
            seen     = 0;
        end else begin
            if (inflight && !out_valid_m) check("busy", busy_m, 1'b1);
            if (in_valid_m && in_ready_m) begin
                acc_cyc  = cyc + 1;
                inflight = 1;
            end
            if (out_valid_m && !seen) begin
                seen     = 1;
                inflight = 0;
                if (q.size() == 0) check("spurious_valid", out_valid_m, 1'b0);
                else               check("latency", 64'(cyc - acc_cyc), 64'(q[0].lat));
            end
            if (out_valid_m && out_ready) begin
                seen = 0;
                if (q.size() != 0) begin
                    e_mon = q.pop_front();
                    check("result", result_m, e_mon.res);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DA*IW-1:0]    iv1, iv2, ivr;
        logic [DC*DA*WW-1:0] wm1, wm2, wmr;
        logic [RW-1:0]       exp1;
        int                  k;

        iv1 = 16'h4321;  wm1 = 32'h1302_1111;   // in=[1,2,3,4], w0=[1,1,1,1], w1=[2,0,3,1]
        iv2 = 16'h0137;  wm2 = 32'hFFFF_1111;   // in=[7,3,1,0], w0=1s, w1=15s
        exp1 = model(iv1, wm1, 4, 1'b0);

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
        in_vec = '0; w_mat = '0; prec = '0; use_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_u, 1'b1);
        check("rst_out_valid", out_valid_u, 1'b0);
        check("rst_busy", busy_u, 1'b0);
        check("rst_result", result_u, '0);
        check("rst_in_ready_s", in_ready_s, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(iv1, wm1, 4, 1'b1, 0);
        wait_done();
        issue(iv2, wm2, 2, 1'b1, 0);
        wait_done();

        // Stall 5 cycles in RUN and 1 cycle in DRAIN.
        issue(iv1, wm1, 4, 1'b1, 6);
        repeat (3) @(posedge clk);
        #1 enable = 1'b0;
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        repeat (13) @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        wait_done();

        // Back-pressure with an in_valid pulse that must be ignored.
        out_ready = 1'b0;
        issue(iv1, wm1, 4, 1'b1, 0);
        k = 0;
        while (!out_valid_u && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_valid", out_valid_u, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_result", result_u, exp1);
            check("bp_in_ready", in_ready_u, 1'b0);
            if (i == 3) begin
                in_vec   = 16'hFFFF;
                in_valid = 1'b1;
            end
            if (i == 5) in_valid = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_in_ready", in_ready_u, 1'b1);
        check("post_hs_out_valid", out_valid_u, 1'b0);
        check("post_hs_result", result_u, exp1);
        issue(iv2, wm2, 2, 1'b1, 0);
        wait_done();

        // Out-of-range and zero precision resolve to full width; plus random operands.
        issue(16'hF0A5, 32'h9C3E_71B2, 0, 1'b1, 0);
        wait_done();
        issue(16'h8F1E, 32'h4D2A_E6F0, 7, 1'b1, 0);
        wait_done();
        issue(16'hFFFF, 32'h0000_0001, 1, 1'b1, 0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            ivr = DA*IW'($urandom);
            wmr = $urandom;
            issue(ivr, wmr, int'($urandom_range(0, 7)), 1'b1, 0);
            wait_done();
        end

        // Reset in the middle of RUN.
        issue(iv1, wm1, 4, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready_u, 1'b1);
        check("midrst_out_valid", out_valid_u, 1'b0);
        check("midrst_busy", busy_u, 1'b0);
        check("midrst_result", result_u, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(iv2, wm2, 2, 1'b1, 0);
        wait_done();

        // Signed weights: w0=[-1,2,0,0], w1=[-8,-8,-8,-8], inputs all 15.
        use_s = 1'b1;
        @(posedge clk); #1;
        issue(16'hFFFF, 32'h8888_002F, 4, 1'b1, 0);
        wait_done();
        issue(16'h5A3C, 32'hF1E2_7D84, 3, 1'b1, 0);
        wait_done();
        use_s = 1'b0;

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
